plru_tracker: RTL

PLRU_TRACKER -- requirements
Module: plru_tracker

---
 rtl/plru_pkg.sv | 12 +
 rtl/plru_victim_decode.sv | 20 ++
 rtl/plru_tracker.sv | 78 +++++++
 3 files changed

// File: rtl/plru_pkg.sv
// plru_pkg: shared FSM type, default geometry and tree-index helpers for the PLRU tracker
package plru_pkg;
  typedef enum logic {IDLE, FLUSH} state_e;
  localparam int DEF_WAYS = 8;
  localparam int DEF_SETS = 16;
  function automatic int num_nodes(input int ways);
    return ways - 1;
  endfunction
  function automatic int child(input int n, input logic b);
    return 2 * n + 1 + int'(b);
  endfunction
endpackage

// File: rtl/plru_victim_decode.sv
// plru_victim_decode: walk a PLRU tree from the root along the node bits to the victim leaf
module plru_victim_decode
  import plru_pkg::*;
#(
  parameter int WAYS = DEF_WAYS
) (
  input  logic [num_nodes(WAYS)-1:0] tree_i,
  output logic [$clog2(WAYS)-1:0]    way_o
);
  localparam int WW = $clog2(WAYS);
  logic [WW-1:0] n;
  always_comb begin
    way_o = '0;
    n = '0;
    for (int l = 0; l < WW; l++) begin
      way_o = (way_o << 1) | WW'(tree_i[n]);
      n = WW'(child(int'(n), tree_i[n]));
    end
  end
endmodule

// File: rtl/plru_tracker.sv
// plru_tracker: per-set tree pseudo-LRU state with registered victim lookup and a
// one-set-per-cycle flush sequencer
module plru_tracker
  import plru_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    touch_valid,
  input  logic [$clog2(SETS)-1:0] touch_set,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  input  logic                    victim_req,
  input  logic [$clog2(SETS)-1:0] victim_set,
  output logic                    victim_valid,
  output logic [$clog2(WAYS)-1:0] victim_way,
  input  logic                    flush,
  output logic                    ready
);
  localparam int WW = $clog2(WAYS);
  localparam int SW = $clog2(SETS);
  localparam int NB = num_nodes(WAYS);
  state_e        state_q;
  logic [SW-1:0] cnt_q;
  logic [NB-1:0] tree_q [SETS];
  logic [NB-1:0] tree_d [SETS];
  logic [NB-1:0] touched;
  logic [NB-1:0] vtree;
  logic [WW-1:0] w;
  logic [WW-1:0] n;
  logic [WW-1:0] dec_way;
  logic          touch_acc;
  logic          victim_acc;
  assign ready      = state_q == IDLE;
  assign touch_acc  = ready && !flush && touch_valid;
  assign victim_acc = ready && !flush && victim_req;
  // A same-set touch is forwarded into the victim lookup of the same cycle
  always_comb begin
    touched = tree_q[touch_set];
    w = touch_way;
    n = '0;
    for (int l = 0; l < WW; l++) begin
      touched[n] = ~w[WW-1];
      n = WW'(child(int'(n), w[WW-1]));
      w = w << 1;
    end
    tree_d = tree_q;
    if (touch_acc) tree_d[touch_set] = touched;
    if (state_q == FLUSH) tree_d[cnt_q] = '0;
    vtree = (touch_acc && touch_set == victim_set) ? touched : tree_q[victim_set];
  end
  plru_victim_decode #(.WAYS(WAYS)) u_decode (
    .tree_i(vtree),
    .way_o (dec_way)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tree_q <= '{default: '0};
    else tree_q <= tree_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      victim_valid <= victim_acc;
      if (victim_acc) victim_way <= dec_way;
      if (state_q == IDLE) begin
        state_q <= flush ? FLUSH : IDLE;
      end else begin
        cnt_q <= cnt_q + SW'(1);
        if (cnt_q == SW'(SETS - 1)) state_q <= IDLE;
      end
    end
  end
endmodule
